// File: rtl/unified_mem_arbiter_pkg.sv
// Shared constants for the unified IF/MEM memory arbiter: state encoding,
// default widths and the starvation limit.
package unified_mem_arbiter_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_BUSY_IF  = 2'd1;
    localparam logic [1:0] ST_BUSY_MEM = 2'd2;

    // Counter width able to hold 0..max inclusive.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch, data-access and RAM-side signals of the arbiter.
// Handshake: each req is held until its one-cycle completion pulse (valid/ack).
interface unified_mem_arbiter_if
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic [DATA_W-1:0] o_if_rdata;
    logic              o_if_valid;
    logic              o_stall_if;

    logic              i_mem_req;
    logic              i_mem_we;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [DATA_W-1:0] i_mem_wdata;
    logic [DATA_W-1:0] o_mem_rdata;
    logic              o_mem_valid;
    logic              o_stall_mem;

    logic              o_ram_req;
    logic              o_ram_we;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] o_ram_wdata;
    logic              i_ram_ack;
    logic [DATA_W-1:0] i_ram_rdata;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_rdata, o_if_valid, o_stall_if,
        input  i_mem_req, i_mem_we, i_mem_addr, i_mem_wdata,
        output o_mem_rdata, o_mem_valid, o_stall_mem,
        output o_ram_req, o_ram_we, o_ram_addr, o_ram_wdata,
        input  i_ram_ack, i_ram_rdata
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_rdata, o_if_valid, o_stall_if,
        output i_mem_req, i_mem_we, i_mem_addr, i_mem_wdata,
        input  o_mem_rdata, o_mem_valid, o_stall_mem,
        input  o_ram_req, o_ram_we, o_ram_addr, o_ram_wdata,
        output i_ram_ack, i_ram_rdata
    );

endinterface

// File: rtl/unified_mem_arbiter_arb_pick.sv
// Winner select for the idle arbiter: MEM has priority unless IF has been
// passed over STARVE_MAX times in a row while contending.
module arb_pick
    import unified_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_if_pend,
    input  logic i_mem_pend,
    input  logic i_idle,
    output logic o_grant_if,
    output logic o_grant_mem
);

    localparam int              CNT_W   = cnt_width(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             starved;

    assign starved     = (cnt_q >= CNT_MAX);
    assign o_grant_mem = i_idle & i_mem_pend & ~(i_if_pend & starved);
    assign o_grant_if  = i_idle & i_if_pend & ~o_grant_mem;

    // Only contested MEM wins count; an uncontested MEM grant leaves it alone.
    always_comb begin
        cnt_d = cnt_q;
        if (o_grant_if) begin
            cnt_d = '0;
        end else if (o_grant_mem && i_if_pend) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port unified memory shared by fetch (IF) and data access (MEM):
// req/ack sequencing toward the RAM, registered results and pipeline stalls.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    unified_mem_arbiter_if.slave   bus,
    output logic [1:0]             o_state_dbg
);

    logic [1:0]        state_q,     state_d;
    logic              ram_req_q,   ram_req_d;
    logic              ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic              if_valid_q,  if_valid_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              mem_valid_q, mem_valid_d;

    logic if_pend, mem_pend, idle, grant_if, grant_mem;

    // A requester still holding req in its completion cycle is not re-granted.
    assign if_pend  = bus.i_if_req  & ~if_valid_q;
    assign mem_pend = bus.i_mem_req & ~mem_valid_q;
    assign idle     = (state_q == ST_IDLE);

    arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_if_pend   (if_pend),
        .i_mem_pend  (mem_pend),
        .i_idle      (idle),
        .o_grant_if  (grant_if),
        .o_grant_mem (grant_mem)
    );

    always_comb begin
        state_d     = state_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_mem) begin
                    state_d     = ST_BUSY_MEM;
                    ram_req_d   = 1'b1;
                    ram_we_d    = bus.i_mem_we;
                    ram_addr_d  = bus.i_mem_addr;
                    ram_wdata_d = bus.i_mem_wdata;
                end else if (grant_if) begin
                    state_d    = ST_BUSY_IF;
                    ram_req_d  = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = bus.i_if_addr;
                end
            end
            ST_BUSY_IF: begin
                if (bus.i_ram_ack) begin
                    state_d    = ST_IDLE;
                    ram_req_d  = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = bus.i_ram_rdata;
                end
            end
            ST_BUSY_MEM: begin
                if (bus.i_ram_ack) begin
                    state_d     = ST_IDLE;
                    ram_req_d   = 1'b0;
                    mem_valid_d = 1'b1;
                    if (!ram_we_q) begin
                        mem_rdata_d = bus.i_ram_rdata;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                ram_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            mem_rdata_q <= '0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            mem_rdata_q <= mem_rdata_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    assign bus.o_ram_req   = ram_req_q;
    assign bus.o_ram_we    = ram_we_q;
    assign bus.o_ram_addr  = ram_addr_q;
    assign bus.o_ram_wdata = ram_wdata_q;
    assign bus.o_if_rdata  = if_rdata_q;
    assign bus.o_if_valid  = if_valid_q;
    assign bus.o_mem_rdata = mem_rdata_q;
    assign bus.o_mem_valid = mem_valid_q;
    assign bus.o_stall_if  = bus.i_if_req  & ~if_valid_q;
    assign bus.o_stall_mem = bus.i_mem_req & ~mem_valid_q;
    assign o_state_dbg     = state_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: RAM responses are driven step by
// step, completions are checked against a per-requester expected queue.
module tb_unified_mem_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_if_q[$];
  logic [31:0] exp_mem_q[$];
  logic [31:0] last_if_m;
  logic [31:0] last_mem_m;
  logic [31:0] data;
  logic [31:0] a_if, a_mem;
  int          cnt_m;
  logic        if_wins;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .bus         (bus.slave),
    .o_state_dbg (state_dbg)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_if;
    checks++;
    assert (exp_if_q.size() != 0) else begin
      failures++;
      $error("FAIL sb_if_empty observed=%0d expected=%0d", 0, 1);
    end
    if (exp_if_q.size() != 0) chk("sb_if_rdata", bus.o_if_rdata, exp_if_q.pop_front());
  endtask

  task automatic pop_mem;
    checks++;
    assert (exp_mem_q.size() != 0) else begin
      failures++;
      $error("FAIL sb_mem_empty observed=%0d expected=%0d", 0, 1);
    end
    if (exp_mem_q.size() != 0) chk("sb_mem_rdata", bus.o_mem_rdata, exp_mem_q.pop_front());
  endtask

  initial begin
    i_rst = 1'b1;
    bus.i_if_req = 0;  bus.i_if_addr = '0;
    bus.i_mem_req = 0; bus.i_mem_we = 0; bus.i_mem_addr = '0; bus.i_mem_wdata = '0;
    bus.i_ram_ack = 0; bus.i_ram_rdata = '0;
    last_if_m = '0; last_mem_m = '0; cnt_m = 0;
    tick; tick;

    // Reset state
    chk("rst_ram_req",   bus.o_ram_req,   0);
    chk("rst_ram_addr",  bus.o_ram_addr,  0);
    chk("rst_if_valid",  bus.o_if_valid,  0);
    chk("rst_mem_valid", bus.o_mem_valid, 0);
    chk("rst_if_rdata",  bus.o_if_rdata,  0);
    chk("rst_mem_rdata", bus.o_mem_rdata, 0);
    chk("rst_state",     state_dbg,       0);
    i_rst = 1'b0;
    tick;

    // IF-only fetch, ack one cycle after req
    bus.i_if_req = 1; bus.i_if_addr = 32'h0000_0040;
    tick;
    chk("if_ram_req",  bus.o_ram_req,  1);
    chk("if_ram_addr", bus.o_ram_addr, 32'h40);
    chk("if_ram_we",   bus.o_ram_we,   0);
    chk("if_stall",    bus.o_stall_if, 1);
    chk("if_state",    state_dbg,      1);
    bus.i_ram_ack = 1; bus.i_ram_rdata = 32'h8C22_0004;
    exp_if_q.push_back(32'h8C22_0004); last_if_m = 32'h8C22_0004;
    tick;
    bus.i_ram_ack = 0; bus.i_ram_rdata = $urandom;
    chk("if_valid",       bus.o_if_valid, 1);
    chk("if_req_dropped", bus.o_ram_req,  0);
    chk("if_stall_done",  bus.o_stall_if, 0);
    pop_if;
    bus.i_if_req = 0;
    tick;
    chk("if_valid_once", bus.o_if_valid, 0);

    // MEM store with 3-cycle ack; IF arrives while busy and must wait
    bus.i_mem_req = 1; bus.i_mem_we = 1; bus.i_mem_addr = 32'h100; bus.i_mem_wdata = 32'hDEAD_BEEF;
    tick;
    bus.i_if_req = 1; bus.i_if_addr = 32'h44;
    for (int c = 0; c < 3; c++) begin
      chk("st_ram_req",   bus.o_ram_req,   1);
      chk("st_ram_we",    bus.o_ram_we,    1);
      chk("st_ram_addr",  bus.o_ram_addr,  32'h100);
      chk("st_ram_wdata", bus.o_ram_wdata, 32'hDEAD_BEEF);
      chk("st_stall_mem", bus.o_stall_mem, 1);
      chk("st_state",     state_dbg,       2);
      if (c == 2) begin
        bus.i_ram_ack = 1; bus.i_ram_rdata = 32'h1111_2222;
        exp_mem_q.push_back(last_mem_m);
      end
      tick;
    end
    bus.i_ram_ack = 0;
    chk("st_mem_valid",   bus.o_mem_valid, 1);
    chk("st_if_valid",    bus.o_if_valid,  0);
    pop_mem;
    bus.i_mem_req = 0; bus.i_mem_we = 0;
    tick;
    chk("st_if_after_addr", bus.o_ram_addr, 32'h44);
    chk("st_if_after_we",   bus.o_ram_we,   0);
    chk("st_mem_valid_once", bus.o_mem_valid, 0);
    bus.i_ram_ack = 1; bus.i_ram_rdata = 32'h1234_5678;
    exp_if_q.push_back(32'h1234_5678); last_if_m = 32'h1234_5678;
    tick;
    bus.i_ram_ack = 0;
    chk("st_if_valid2", bus.o_if_valid, 1);
    pop_if;
    bus.i_if_req = 0;
    tick;

    // Contested rounds: both requesters rise together in a quiet IDLE cycle
    // and drop in the winner's completion cycle, so each round is contested.
    for (int r = 0; r < 10; r++) begin
      if_wins = (cnt_m == 4);
      if (if_wins) cnt_m = 0; else cnt_m++;
      a_if  = 32'h1000 + 32'(r * 4);
      a_mem = 32'h2000 + 32'(r * 4);
      bus.i_if_req = 1;  bus.i_if_addr = a_if;
      bus.i_mem_req = 1; bus.i_mem_we = 0; bus.i_mem_addr = a_mem;
      tick;
      chk("sv_ram_addr", bus.o_ram_addr, if_wins ? a_if : a_mem);
      chk("sv_ram_we",   bus.o_ram_we,   0);
      data = $urandom;
      bus.i_ram_ack = 1; bus.i_ram_rdata = data;
      if (if_wins) begin exp_if_q.push_back(data); last_if_m = data; end
      else begin exp_mem_q.push_back(data); last_mem_m = data; end
      tick;
      bus.i_ram_ack = 0;
      chk("sv_if_valid",  bus.o_if_valid,  if_wins ? 1 : 0);
      chk("sv_mem_valid", bus.o_mem_valid, if_wins ? 0 : 1);
      chk("sv_loser_stall", if_wins ? bus.o_stall_mem : bus.o_stall_if, 1);
      if (if_wins) pop_if; else pop_mem;
      bus.i_if_req = 0; bus.i_mem_req = 0;
      tick;
    end

    // Reset during BUSY_MEM with ack outstanding
    bus.i_mem_req = 1; bus.i_mem_we = 0; bus.i_mem_addr = 32'h200;
    tick;
    chk("ra_ram_req_before", bus.o_ram_req, 1);
    #2 i_rst = 1'b1;
    #1;
    chk("ra_ram_req_async", bus.o_ram_req, 0);
    chk("ra_state_async",   state_dbg,     0);
    last_if_m = '0; last_mem_m = '0;
    tick;
    bus.i_mem_req = 0;
    i_rst = 1'b0;
    bus.i_ram_ack = 1; bus.i_ram_rdata = 32'h5555_AAAA;
    tick;
    bus.i_ram_ack = 0;
    chk("ra_late_ack_mem_valid", bus.o_mem_valid, 0);
    chk("ra_late_ack_if_valid",  bus.o_if_valid,  0);
    chk("ra_late_ack_mem_rdata", bus.o_mem_rdata, last_mem_m);
    chk("ra_late_ack_ram_req",   bus.o_ram_req,   0);
    bus.i_if_req = 1; bus.i_if_addr = 32'h80;
    tick;
    chk("ra_if_addr", bus.o_ram_addr, 32'h80);
    tick;
    bus.i_ram_ack = 1; bus.i_ram_rdata = 32'hCAFE_F00D;
    exp_if_q.push_back(32'hCAFE_F00D); last_if_m = 32'hCAFE_F00D;
    tick;
    bus.i_ram_ack = 0;
    chk("ra_if_valid", bus.o_if_valid, 1);
    pop_if;
    bus.i_if_req = 0;
    tick;

    // Requester keeps req high through its completion cycle
    bus.i_if_req = 1; bus.i_if_addr = 32'h300;
    tick;
    data = $urandom;
    bus.i_ram_ack = 1; bus.i_ram_rdata = data;
    exp_if_q.push_back(data); last_if_m = data;
    tick;
    bus.i_ram_ack = 0;
    chk("hold_valid", bus.o_if_valid, 1);
    pop_if;
    tick;
    chk("hold_no_dup_req",   bus.o_ram_req,  0);
    chk("hold_no_dup_state", state_dbg,      0);
    chk("hold_valid_low",    bus.o_if_valid, 0);
    tick;
    chk("hold_regrant_req",  bus.o_ram_req,  1);
    chk("hold_regrant_addr", bus.o_ram_addr, 32'h300);
    data = $urandom;
    bus.i_ram_ack = 1; bus.i_ram_rdata = data;
    exp_if_q.push_back(data); last_if_m = data;
    tick;
    bus.i_ram_ack = 0;
    chk("hold_valid2", bus.o_if_valid, 1);
    pop_if;
    bus.i_if_req = 0;
    tick;

    // Spurious ack while idle with nothing pending
    bus.i_ram_ack = 1; bus.i_ram_rdata = 32'hBAD0_BAD0;
    tick; tick;
    bus.i_ram_ack = 0;
    chk("sp_state",     state_dbg,       0);
    chk("sp_ram_req",   bus.o_ram_req,   0);
    chk("sp_if_valid",  bus.o_if_valid,  0);
    chk("sp_mem_valid", bus.o_mem_valid, 0);
    chk("sp_if_rdata",  bus.o_if_rdata,  last_if_m);
    chk("sp_mem_rdata", bus.o_mem_rdata, last_mem_m);

    chk("sb_if_drained",  32'(exp_if_q.size()),  0);
    chk("sb_mem_drained", 32'(exp_mem_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
